// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUS_I = 2'd1,
        ARB_BUS_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // On a conflict, the requester that was not served last wins.
    function automatic grant_t pick_on_conflict(input grant_t last);
        return (last == GRANT_I) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/bus_req_reg.sv
// rtl/bus_req_reg.sv - grant-time latch of the bus request fields
module bus_req_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic                i_we,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_be,
    output logic                o_we
);

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic                r_we;

    // Capture fields when a grant is made; clear wins so the bus returns to zero on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
        end else if (i_clear) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_be    <= i_be;
            r_we    <= i_we;
        end
    end

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_be    = r_be;
    assign o_we    = r_we;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory bus between fetch and load/store
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    grant_t            r_last_grant;
    grant_t            w_last_grant_nxt;

    logic              r_read;
    logic              r_write;
    logic              r_i_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_i_ok;
    logic              w_d_ok;
    logic              w_grant_i;
    logic              w_grant_d;

    logic              w_load;
    logic              w_clear;
    logic              w_read_nxt;
    logic              w_write_nxt;
    logic              w_i_done_nxt;
    logic              w_d_done_nxt;
    logic              w_i_cap;
    logic              w_d_cap;

    logic [ADDR_W-1:0] w_ld_addr;
    logic [DATA_W-1:0] w_ld_wdata;
    logic [BE_W-1:0]   w_ld_be;
    logic              w_ld_we;
    logic              w_lat_we;

    // Arbitration: a requester is masked during its own done cycle; conflicts go to the one not served last.
    always_comb begin
        w_i_ok    = i_req & ~r_i_done;
        w_d_ok    = d_req & ~r_d_done;
        w_grant_d = w_d_ok & (~w_i_ok | (pick_on_conflict(r_last_grant) == GRANT_D));
        w_grant_i = w_i_ok & ~w_grant_d;
        w_ld_addr  = w_grant_d ? d_addr  : i_addr;
        w_ld_wdata = w_grant_d ? d_wdata : '0;
        w_ld_be    = w_grant_d ? d_be    : BE_W'(BE_WORD);
        w_ld_we    = w_grant_d & d_we;
    end

    bus_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus_req_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_addr  (w_ld_addr),
        .i_wdata (w_ld_wdata),
        .i_be    (w_ld_be),
        .i_we    (w_ld_we),
        .o_addr  (address),
        .o_wdata (writedata),
        .o_be    (byteenable),
        .o_we    (w_lat_we)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: grant from idle, leave a bus state when waitrequest is low at the edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_i) begin
                    w_next_state = ARB_BUS_I;
                end else if (w_grant_d) begin
                    w_next_state = ARB_BUS_D;
                end
            end
            ARB_BUS_I, ARB_BUS_D: begin
                if (!waitrequest) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes, done pulses, read-data captures.
    always_comb begin
        w_load           = 1'b0;
        w_clear          = 1'b0;
        w_read_nxt       = r_read;
        w_write_nxt      = r_write;
        w_i_done_nxt     = 1'b0;
        w_d_done_nxt     = 1'b0;
        w_i_cap          = 1'b0;
        w_d_cap          = 1'b0;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_i) begin
                    w_load      = 1'b1;
                    w_read_nxt  = 1'b1;
                    w_write_nxt = 1'b0;
                end else if (w_grant_d) begin
                    w_load      = 1'b1;
                    w_read_nxt  = ~d_we;
                    w_write_nxt = d_we;
                end
            end
            ARB_BUS_I: begin
                if (!waitrequest) begin
                    w_clear          = 1'b1;
                    w_read_nxt       = 1'b0;
                    w_write_nxt      = 1'b0;
                    w_i_done_nxt     = 1'b1;
                    w_i_cap          = 1'b1;
                    w_last_grant_nxt = GRANT_I;
                end
            end
            ARB_BUS_D: begin
                if (!waitrequest) begin
                    w_clear          = 1'b1;
                    w_read_nxt       = 1'b0;
                    w_write_nxt      = 1'b0;
                    w_d_done_nxt     = 1'b1;
                    w_d_cap          = ~w_lat_we;
                    w_last_grant_nxt = GRANT_D;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end
        endcase
    end

    // Registered strobes, done pulses, read data and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_last_grant <= GRANT_I;
        end else begin
            r_read       <= w_read_nxt;
            r_write      <= w_write_nxt;
            r_i_done     <= w_i_done_nxt;
            r_d_done     <= w_d_done_nxt;
            r_last_grant <= w_last_grant_nxt;
            if (w_i_cap) begin
                r_i_rdata <= readdata;
            end
            if (w_d_cap) begin
                r_d_rdata <= readdata;
            end
        end
    end

    assign read    = r_read;
    assign write   = r_write;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign busy    = (r_state != ARB_IDLE);

endmodule
